in_service_control: RTL

IN_SERVICE_CONTROL -- requirements
Module: in_service_control

---
 rtl/in_service_control.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/in_service_control.sv
`default_nettype none
// ============================================================================
//  Module      : in_service_control
//  Description : 8259-style in-service register (ISR) and priority resolver.
//                Tracks the INTA acknowledge sequence and handles specific,
//                non-specific and automatic EOI. Supports rotating priority.
//
//  Ports
//    clock                 rising-edge clock for all state
//    reset                 asynchronous, active-high reset
//    interrupt_request     pending requests (already masked), bit n = IRn
//    interrupt_acknowledge one-cycle strobe per INTA falling edge (2 per ack)
//    end_of_interrupt      one-cycle non-specific EOI strobe
//    specific_eoi          one-cycle specific EOI strobe (level on eoi_level)
//    eoi_level             level cleared by specific_eoi
//    rotate_on_eoi         when 1, every clearing EOI also rotates priority
//    auto_eoi_mode         when 1, ISR bit clears on the second INTA strobe
//    in_service_register   current ISR
//    priority_rotate       lowest-priority level
//    interrupt             registered INT request to the CPU
//    acknowledged_level    level latched on the first INTA strobe
//    acknowledged_valid    1 while acknowledged_level is a real request
//
//  Revision    : 1.0  initial release
// ============================================================================
module in_service_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt_request,
    input  logic       interrupt_acknowledge,
    input  logic       end_of_interrupt,
    input  logic       specific_eoi,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    input  logic       auto_eoi_mode,
    output logic [7:0] in_service_register,
    output logic [2:0] priority_rotate,
    output logic       interrupt,
    output logic [2:0] acknowledged_level,
    output logic       acknowledged_valid
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACK1_DONE = 2'd1,
        ST_ACK2_DONE = 2'd2
    } state_t;

    // Scan from the highest priority level (rot+1) downwards; first set ISR bit
    // is the highest-ranked one. Returns {found, level}.
    function automatic logic [3:0] f_top(input logic [7:0] isr, input logic [2:0] rot);
        logic       found;
        logic [2:0] sel;
        logic [2:0] lvl;
        found = 1'b0;
        sel   = 3'd0;
        for (int r = 0; r < 8; r++) begin
            lvl = rot + 3'd1 + 3'(r);
            if (!found && isr[lvl]) begin
                found = 1'b1;
                sel   = lvl;
            end
        end
        return {found, sel};
    endfunction

    // Same scan, but the first in-service bit encountered blocks every request
    // at the same or lower rank. Returns {found, level}.
    function automatic logic [3:0] f_qual(input logic [7:0] req, input logic [7:0] isr,
                                          input logic [2:0] rot);
        logic       found;
        logic       blocked;
        logic [2:0] sel;
        logic [2:0] lvl;
        found   = 1'b0;
        blocked = 1'b0;
        sel     = 3'd0;
        for (int r = 0; r < 8; r++) begin
            lvl = rot + 3'd1 + 3'(r);
            if (!found && !blocked) begin
                if (isr[lvl]) begin
                    blocked = 1'b1;
                end else if (req[lvl]) begin
                    found = 1'b1;
                    sel   = lvl;
                end
            end
        end
        return {found, sel};
    endfunction

    state_t     r_state;
    logic [7:0] r_isr;
    logic [2:0] r_rot;
    logic       r_int;
    logic [2:0] r_ack_level;
    logic       r_ack_valid;

    state_t     w_state_next;
    logic [7:0] w_clear;
    logic [7:0] w_set;
    logic [7:0] w_isr_next;
    logic [2:0] w_rot_next;
    logic [2:0] w_ack_level_next;
    logic       w_ack_valid_next;
    logic       w_eoi_hit;
    logic [2:0] w_eoi_lvl;
    logic       w_aeoi_rot;
    logic [3:0] w_top;
    logic [3:0] w_qual;
    logic [3:0] w_qual_post;
    logic       w_int_next;

    // Both the EOI target and the acknowledged level use the pre-edge state.
    assign w_top  = f_top(r_isr, r_rot);
    assign w_qual = f_qual(interrupt_request, r_isr, r_rot);

    always_comb begin
        w_state_next     = r_state;
        w_clear          = 8'h00;
        w_set            = 8'h00;
        w_rot_next       = r_rot;
        w_ack_level_next = r_ack_level;
        w_ack_valid_next = r_ack_valid;
        w_eoi_hit        = 1'b0;
        w_eoi_lvl        = 3'd0;
        w_aeoi_rot       = 1'b0;

        // Specific EOI takes precedence; a non-specific EOI is then ignored.
        if (specific_eoi) begin
            if (r_isr[eoi_level]) begin
                w_eoi_hit = 1'b1;
                w_eoi_lvl = eoi_level;
            end
        end else if (end_of_interrupt && w_top[3]) begin
            w_eoi_hit = 1'b1;
            w_eoi_lvl = w_top[2:0];
        end
        if (w_eoi_hit) begin
            w_clear[w_eoi_lvl] = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (interrupt_acknowledge) begin
                    w_state_next     = ST_ACK1_DONE;
                    w_ack_valid_next = w_qual[3];
                    // Spurious acknowledge reports level 7 and sets nothing.
                    w_ack_level_next = w_qual[3] ? w_qual[2:0] : 3'd7;
                    if (w_qual[3]) begin
                        w_set[w_qual[2:0]] = 1'b1;
                    end
                end
            end
            ST_ACK1_DONE: begin
                if (interrupt_acknowledge) begin
                    w_state_next = ST_IDLE;
                    if (auto_eoi_mode && r_ack_valid) begin
                        w_clear[r_ack_level] = 1'b1;
                        w_aeoi_rot           = rotate_on_eoi;
                    end
                end
            end
            default: begin
                // ACK2_DONE is transient and never held.
                w_state_next = ST_IDLE;
            end
        endcase

        // An explicit EOI rotation wins over the auto-EOI rotation.
        if (w_eoi_hit && rotate_on_eoi) begin
            w_rot_next = w_eoi_lvl;
        end else if (w_aeoi_rot) begin
            w_rot_next = r_ack_level;
        end
    end

    assign w_isr_next  = (r_isr & ~w_clear) | w_set;
    assign w_qual_post = f_qual(interrupt_request, w_isr_next, w_rot_next);
    assign w_int_next  = (w_state_next == ST_IDLE) && w_qual_post[3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_isr       <= 8'h00;
            r_rot       <= 3'd7;
            r_int       <= 1'b0;
            r_ack_level <= 3'd0;
            r_ack_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_isr       <= w_isr_next;
            r_rot       <= w_rot_next;
            r_int       <= w_int_next;
            r_ack_level <= w_ack_level_next;
            r_ack_valid <= w_ack_valid_next;
        end
    end

    assign in_service_register = r_isr;
    assign priority_rotate     = r_rot;
    assign interrupt           = r_int;
    assign acknowledged_level  = r_ack_level;
    assign acknowledged_valid  = r_ack_valid;

endmodule
`default_nettype wire
